gaussian_blur: RTL and testbench
================================

Name: gaussian_blur

Overview:
- Streaming 3x3 Gaussian blur accelerator for a single-pixel-per-cycle image pipeline, in the form produced by our Halide/clockwork flow.
- Pulls one 16-bit pixel per cycle from the input global-wrapper stream.
- Computes the (1 2 1 / 2 4 2 / 1 2 1)/16 convolution over the valid (non-padded) region.
- Pushes one 16-bit result per valid cycle to the output stencil stream.
- A frame starts on a flush pulse and then runs free.

Parameters:
- IMG_W, 64, input image width in pixels (output width IMG_W-2).
- IMG_H, 64, input image height in rows (output height IMG_H-2).
- DATA_W, 16, pixel width in bits.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous frame start; active-high, sampled on clk.
- hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en  output  1  DUT consumes the input word this cycle.
- hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read  input  DATA_W x [0:0]  input pixel (1-element unpacked array); always valid, no backpressure.
- hw_output_stencil_op_hcompute_hw_output_stencil_write_valid  output  1  output word valid this cycle.
- hw_output_stencil_op_hcompute_hw_output_stencil_write  output  DATA_W x [0:0]  blurred pixel (1-element unpacked array).

Behaviour:
- Reset (rst_n low, async):
  - All counters and the pipeline clear; FSM goes to IDLE.
  - read_en=0, write_valid=0, write[0]=0.
  - Line-buffer contents need not be cleared.
- FSM states:
  - IDLE: read_en=0; waits for flush.
  - RUN: streams the frame.
  - DRAIN: read_en=0 while the last results exit the pipeline, then returns to IDLE.
- Flush:
  - A cycle with flush=1 (in any state) clears the counters and the pipeline valid bits, sets x=0, y=0, and enters RUN on the next cycle.
  - Flush held for several cycles keeps the block in the cleared state.
  - First read_en is the first cycle after flush is sampled low.
- RUN:
  - read_en=1 every cycle for exactly IMG_W*IMG_H consecutive cycles, raster order (x fastest).
  - Data is sampled on the same rising edge where read_en=1.
  - After the last pixel (x=IMG_W-1, y=IMG_H-1), go to DRAIN.
- Storage:
  - Two line buffers of IMG_W x DATA_W (rows y-1, y-2); single-port RAM or register array.
  - A 3x3 window shift register.
- Arithmetic, computed when pixel (x,y) with x>=2 and y>=2 is accepted:
  - out(ox=x-2, oy=y-2) = (sum over dy,dx in 0..2 of w[dy][dx]*in[oy+dy][ox+dx]) >> 4.
  - w = 1 2 1 / 2 4 2 / 1 2 1.
  - Sum held at DATA_W+4 bits, never overflows; shift is logical, truncating (no rounding).
  - Result fits DATA_W.
- Latency: write_valid asserts exactly 2 clk cycles after the accepting edge of pixel (ox+2, oy+2).
  - Pipeline: window register, then adder/shift register.
  - write[0] is valid only while write_valid=1 and holds its last value otherwise.
- Output count: exactly (IMG_W-2)*(IMG_H-2) = 3844 valid pulses per frame (defaults), raster order.
  - write_valid is low for the 2 columns at each row start and for the first 2 rows.
- Boundaries:
  - No wrap of window across rows; columns 0..1 of each row never produce output.
  - Flush mid-frame aborts the frame: no further valid pulses from the old frame (including those in flight), and the new frame starts clean.
  - Reset mid-frame returns to IDLE; no output until the next flush.

Decomposition:
- Package gaussian_pkg: DATA_W, IMG_W, IMG_H defaults; kernel weight constants; FSM state enum (IDLE, RUN, DRAIN); derived counts OUT_W, OUT_H, PIPE_LAT=2.
- One sub-module: gaussian_line_buffer, a parameterised 2-row delay line exposing the taps (row y, y-1, y-2) at the current column.
- The top holds the FSM, counters, window and adder tree.

Test Plan:
- Reset then flush 10 ns, constant input 100 -> read_en high 4096 cycles; 3844 write_valid pulses; every write[0]=100.
- Constant input 0xFFFF -> every output 0xFFFF (sum 1048560 >> 4), no overflow.
- Impulse (in[10][10]=1600, else 0) -> out(8..10, 8..10) = 100,200,100 / 200,400,200 / 100,200,100; all others 0.
- Random input ($urandom, driven at negedge) vs. software reference model -> bit-exact match, first valid 2 cycles after accepting pixel (2,2).
- Flush asserted at pixel 2000 -> no stale outputs; the following frame yields exactly 3844 correct outputs.
- rst_n low mid-frame -> read_en, write_valid and write go to 0 immediately (async); block stays idle until the next flush.

Source files
------------

// File: rtl/gaussian_pkg.sv
// gaussian_pkg: shared sizes, kernel weights and FSM state type for the 3x3 Gaussian blur.
package gaussian_pkg;
  localparam int DATA_W = 16;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int OUT_W = IMG_W - 2;
  localparam int OUT_H = IMG_H - 2;
  localparam int PIPE_LAT = 2;
  localparam int K_SHIFT = 4;
  localparam int KW [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/gaussian_line_buffer.sv
// gaussian_line_buffer: two-row delay line; taps for rows y, y-1, y-2 at the current column
// come out registered, as from a synchronous-read RAM.
module gaussian_line_buffer #(
  parameter int W = 64,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [$clog2(W)-1:0] col,
  input  logic [DW-1:0]        din,
  output logic [DW-1:0]        row0_q,
  output logic [DW-1:0]        row1_q,
  output logic [DW-1:0]        row2_q
);
  logic [DW-1:0] line1 [W];
  logic [DW-1:0] line2 [W];
  always_ff @(posedge clk)
    if (en) begin
      line1[col] <= din;
      line2[col] <= line1[col];
      row0_q <= din;
      row1_q <= line1[col];
      row2_q <= line2[col];
    end
endmodule

// File: rtl/gaussian_blur.sv
// gaussian_blur: streaming 3x3 (1 2 1/2 4 2/1 2 1)/16 blur, one pixel per cycle,
// frame started by flush; pipeline is line-buffer taps, window, adder/shift.
module gaussian_blur #(
  parameter int IMG_W = gaussian_pkg::IMG_W,
  parameter int IMG_H = gaussian_pkg::IMG_H,
  parameter int DATA_W = gaussian_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en,
  input  logic [DATA_W-1:0] hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read [0:0],
  output logic              hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
  output logic [DATA_W-1:0] hw_output_stencil_op_hcompute_hw_output_stencil_write [0:0]
);
  import gaussian_pkg::*;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int SUM_W = DATA_W + 4;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic rd_q, rd_d, acc_q, acc_d, tvld_q, tvld_d;
  logic win_vld_q, win_vld_d, out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] tap [3];
  logic [DATA_W-1:0] row0, row1, row2;
  logic [SUM_W-1:0] sum;
  logic accept, last_col, last;

  assign accept = rd_q & ~flush;
  assign last_col = x_q == XW'(IMG_W - 1);
  assign last = last_col && y_q == YW'(IMG_H - 1);

  gaussian_line_buffer #(.W(IMG_W), .DW(DATA_W)) u_lb (
    .clk    (clk),
    .en     (accept),
    .col    (x_q),
    .din    (hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read[0]),
    .row0_q (row0),
    .row1_q (row1),
    .row2_q (row2)
  );

  always_comb begin
    tap[0] = row2;
    tap[1] = row1;
    tap[2] = row0;
    sum = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        sum = sum + SUM_W'(win_q[r][c]) * SUM_W'(KW[r][c]);
    win_d = win_q;
    if (acc_q)
      for (int r = 0; r < 3; r++)
        win_d[r] = '{win_q[r][1], win_q[r][2], tap[r]};
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    rd_d = rd_q;
    acc_d = accept;
    tvld_d = accept && x_q >= XW'(2) && y_q >= YW'(2);
    // flush kills everything in flight so an aborted frame never leaks a result
    win_vld_d = tvld_q & ~flush;
    out_vld_d = win_vld_q & ~flush;
    out_d = out_vld_d ? sum[SUM_W-1:K_SHIFT] : out_q;
    if (flush) begin
      state_d = RUN;
      x_d = '0;
      y_d = '0;
      rd_d = 1'b0;
    end else if (state_q == RUN) begin
      rd_d = ~(accept & last);
      if (accept) begin
        x_d = last_col ? '0 : x_q + 1'b1;
        y_d = last ? '0 : last_col ? y_q + 1'b1 : y_q;
        state_d = last ? DRAIN : RUN;
      end
    end else if (state_q == DRAIN && !acc_q && !win_vld_q && !out_vld_q) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      rd_q <= 1'b0;
      acc_q <= 1'b0;
      tvld_q <= 1'b0;
      win_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q <= '0;
      win_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      rd_q <= rd_d;
      acc_q <= acc_d;
      tvld_q <= tvld_d;
      win_vld_q <= win_vld_d;
      out_vld_q <= out_vld_d;
      out_q <= out_d;
      win_q <= win_d;
    end

  assign hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en = rd_q;
  assign hw_output_stencil_op_hcompute_hw_output_stencil_write_valid = out_vld_q;
  assign hw_output_stencil_op_hcompute_hw_output_stencil_write[0] = out_q;
endmodule

// File: tb/tb_gaussian_blur.sv
// tb_gaussian_blur: scoreboard bench; driver queues expected pixels, monitor checks each write_valid.
module tb_gaussian_blur;
  import gaussian_pkg::*;
  localparam int W = IMG_W;
  localparam int H = IMG_H;
  localparam int IMP [3][3] = '{'{100, 200, 100}, '{200, 400, 200}, '{100, 200, 100}};
  typedef struct {
    logic [DATA_W-1:0] val;
    int at;
  } exp_t;
  logic clk = 0;
  logic rst_n = 1;
  logic flush = 0;
  logic rd_en, wr_vld;
  logic [DATA_W-1:0] din [0:0];
  logic [DATA_W-1:0] dout [0:0];
  logic [DATA_W-1:0] img [H][W];
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int total_outs = 0;

  gaussian_blur #(.IMG_W(W), .IMG_H(H), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read_en (rd_en),
    .hw_input_stencil_op_hcompute_hw_input_global_wrapper_stencil_read    (din),
    .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid          (wr_vld),
    .hw_output_stencil_op_hcompute_hw_output_stencil_write                (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && wr_vld) begin
      total_outs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_output: got %0d with no output pending (cycle %0d)", dout[0], cyc);
      end else begin
        e = exp_q.pop_front();
        check("pixel", dout[0], e.val);
        check("latency", cyc - e.at, PIPE_LAT);
      end
    end
  end

  function automatic logic [DATA_W-1:0] conv(input int ox, input int oy);
    int s = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        s += KW[dy][dx] * int'(img[oy+dy][ox+dx]);
    return DATA_W'(s >> 4);
  endfunction

  function automatic logic [DATA_W-1:0] expect_val(input int mode, input logic [DATA_W-1:0] cval,
                                                   input int ox, input int oy);
    if (mode == 0) return cval;
    if (mode == 1) return (ox >= 8 && ox <= 10 && oy >= 8 && oy <= 10) ? DATA_W'(IMP[oy-8][ox-8]) : '0;
    return conv(ox, oy);
  endfunction

  // mode: 0 constant cval, 1 impulse, 2 random; abort_at >= 0 aborts by flush or by reset
  task automatic run_frame(input int mode, input logic [DATA_W-1:0] cval, input int flush_len,
                           input int abort_at, input bit abort_rst);
    int n = 0;
    int guard = 0;
    int base;
    bit first = 1;
    bit idle = 0;
    exp_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = mode == 0 ? cval : mode == 1 ? ((x == 10 && y == 10) ? DATA_W'(1600) : '0)
                                                 : DATA_W'($urandom);
    base = total_outs;
    @(negedge clk); #1 flush = 1;
    repeat (flush_len - 1) begin
      @(negedge clk); #1 check("rd_en_in_flush", rd_en, 0);
    end
    @(negedge clk); #1 flush = 0;
    while (n < W * H && guard < W * H + 100) begin
      @(negedge clk); #1 guard++;
      if (first) begin
        check("first_rd_en", rd_en, 1);
        first = 0;
      end
      if (rd_en) begin
        int x, y;
        x = n % W;
        y = n / W;
        if (n == abort_at) begin
          if (abort_rst) begin
            rst_n = 0;
            #1;
            check("rst_rd_en", rd_en, 0);
            check("rst_write_valid", wr_vld, 0);
            check("rst_write", dout[0], 0);
            exp_q.delete();
            @(negedge clk); #1 rst_n = 1;
            repeat (10) begin
              @(negedge clk);
              idle |= rd_en | wr_vld;
            end
            check("idle_after_reset", idle, 0);
          end else begin
            flush = 1;
            exp_q.delete();
          end
          return;
        end
        din[0] = img[y][x];
        if (x >= 2 && y >= 2) begin
          e.val = expect_val(mode, cval, x - 2, y - 2);
          e.at = cyc + 1;
          exp_q.push_back(e);
        end
        n++;
      end
    end
    check("pixels_read", n, W * H);
    @(negedge clk); #1 check("rd_en_after_frame", rd_en, 0);
    repeat (8) @(negedge clk);
    #1;
    check("outputs_per_frame", total_outs - base, OUT_W * OUT_H);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    din[0] = '0;
    #2 rst_n = 0;
    #10;
    check("reset_rd_en", rd_en, 0);
    check("reset_write_valid", wr_vld, 0);
    check("reset_write", dout[0], 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    repeat (5) @(negedge clk);
    check("idle_rd_en", rd_en, 0);
    run_frame(0, 16'd100, 1, -1, 0);
    run_frame(0, 16'hFFFF, 3, -1, 0);
    run_frame(1, 16'd0, 1, -1, 0);
    run_frame(2, 16'd0, 1, -1, 0);
    run_frame(2, 16'd0, 1, 2000, 0);
    run_frame(2, 16'd0, 1, -1, 0);
    run_frame(2, 16'd0, 1, 1500, 1);
    run_frame(0, 16'd100, 1, -1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
